// File: rtl/mold_pkg.sv
// Shared widths, protocol constants and state encoding for the MoldUDP64 sequencing controller.
package mold_pkg;

  localparam int SID_W = 80;
  localparam int SEQ_W = 64;
  localparam int ML_W  = 16;

  localparam logic [ML_W-1:0] MOLD_CNT_EOS = 16'hFFFF;
  localparam logic [ML_W-1:0] MOLD_CNT_HB  = 16'h0000;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    IDLE     = 2'd1,
    PKT      = 2'd2,
    EOS      = 2'd3
  } mold_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/mold_seq_cmp.sv
// Unsigned magnitude compare of a and b, plus |a-b| clamped to cap.
module mold_seq_cmp #(
  parameter int W  = 64,
  parameter int CW = 16
) (
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [CW-1:0] cap,
  output logic          gt,
  output logic          lt,
  output logic [CW-1:0] min_diff
);

  logic [W-1:0] diff_s;

  // Magnitude compare and clamped absolute difference
  always_comb begin
    gt     = (a > b);
    lt     = (a < b);
    diff_s = gt ? (a - b) : (b - a);
    if (diff_s > {{(W-CW){1'b0}}, cap}) begin
      min_diff = cap;
    end else begin
      min_diff = diff_s[CW-1:0];
    end
  end

endmodule

// File: rtl/mold_seq_ctrl.sv
// MoldUDP64 session lock, sequence tracking, forward/drop gating and gap/error reporting.
// Define MOLD_SEQ_STATS_EN to build the saturating statistics counters; otherwise stat ports read 0.
module mold_seq_ctrl
  import mold_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             hdr_v_i,
  input  logic [SID_W-1:0] hdr_sid_i,
  input  logic [SEQ_W-1:0] hdr_seq_i,
  input  logic [ML_W-1:0]  hdr_cnt_i,
  input  logic             msg_end_i,
  input  logic             pkt_end_i,
  output logic             msg_accept_o,
  output logic [SEQ_W-1:0] msg_seq_o,
  output logic             locked_o,
  output logic             eos_o,
  output logic             gap_v_o,
  output logic [SEQ_W-1:0] gap_seq_o,
  output logic [ML_W-1:0]  gap_cnt_o,
  output logic             sid_err_o,
  output logic             trunc_err_o,
  output logic [31:0]      stat_acc_o,
  output logic [31:0]      stat_dup_o,
  output logic [31:0]      stat_gap_o
);

  mold_state_e      state_r, state_n;
  logic [SID_W-1:0] sid_r, sid_n;
  logic [SEQ_W-1:0] expected_r, exp_n, cur_seq_r, cur_n, gap_seq_r, gap_seq_n;
  logic [ML_W-1:0]  remaining_r, rem_n, skip_r, skip_n, gap_cnt_r, gap_cnt_n;
  logic             drop_all_r, drop_n, locked_r, locked_n, eos_r, eos_n;
  logic             gap_v_r, gap_v_n, sid_err_r, sid_err_n, trunc_r, trunc_n;
  logic             accept_r, accept_n, hdr_go_s;
  logic [SEQ_W-1:0] exp_base_s;
  logic             gap_gt_s, gap_lt_s, skip_gt_s, skip_lt_s, cmp_unused_s;
  logic [ML_W-1:0]  gap_min_s, skip_min_s;

  // Before lock the header itself defines the expected sequence, so no gap or skip can arise
  assign exp_base_s = (state_r == UNLOCKED) ? hdr_seq_i : expected_r;

  mold_seq_cmp #(.W(SEQ_W), .CW(ML_W)) u_gap_cmp (
    .a(hdr_seq_i), .b(exp_base_s), .cap(MOLD_CNT_EOS),
    .gt(gap_gt_s), .lt(gap_lt_s), .min_diff(gap_min_s)
  );

  mold_seq_cmp #(.W(SEQ_W), .CW(ML_W)) u_skip_cmp (
    .a(exp_base_s), .b(hdr_seq_i), .cap(hdr_cnt_i),
    .gt(skip_gt_s), .lt(skip_lt_s), .min_diff(skip_min_s)
  );

  assign cmp_unused_s = &{1'b0, gap_lt_s, skip_lt_s};

  // Next-state, counter and pulse computation
  always_comb begin
    state_n   = state_r;
    sid_n     = sid_r;
    exp_n     = expected_r;
    cur_n     = cur_seq_r;
    rem_n     = remaining_r;
    skip_n    = skip_r;
    drop_n    = drop_all_r;
    locked_n  = locked_r;
    eos_n     = eos_r;
    gap_v_n   = 1'b0;
    gap_seq_n = gap_seq_r;
    gap_cnt_n = gap_cnt_r;
    sid_err_n = 1'b0;
    trunc_n   = 1'b0;
    hdr_go_s  = 1'b0;

    case (state_r)
      UNLOCKED: begin
        if (hdr_v_i) begin
          sid_n    = hdr_sid_i;
          locked_n = 1'b1;
          hdr_go_s = 1'b1;
        end else begin
          hdr_go_s = 1'b0;
        end
      end
      IDLE: begin
        hdr_go_s = hdr_v_i;
      end
      PKT: begin
        if (hdr_v_i) begin
          trunc_n  = 1'b1;
          hdr_go_s = 1'b1;
        end else begin
          if (msg_end_i) begin
            cur_n = cur_seq_r + 64'd1;
            rem_n = remaining_r - 16'd1;
            if (skip_r != 16'd0) begin
              skip_n = skip_r - 16'd1;
            end else if (!drop_all_r) begin
              exp_n = expected_r + 64'd1;
            end else begin
              exp_n = expected_r;
            end
            if (remaining_r == 16'd1) begin
              state_n = IDLE;
            end else begin
              state_n = PKT;
            end
          end else begin
            cur_n = cur_seq_r;
          end
          // A tlast that coincides with the final message is a clean finish
          if (pkt_end_i && !(msg_end_i && (remaining_r == 16'd1))) begin
            trunc_n = 1'b1;
            state_n = IDLE;
          end else begin
            trunc_n = 1'b0;
          end
        end
      end
      EOS: begin
        state_n = EOS;
      end
      default: begin
        state_n = UNLOCKED;
      end
    endcase

    if (hdr_go_s) begin
      if ((state_r != UNLOCKED) && (hdr_sid_i != sid_r)) begin
        sid_err_n = 1'b1;
        drop_n    = 1'b1;
        skip_n    = 16'd0;
        rem_n     = hdr_cnt_i;
        cur_n     = hdr_seq_i;
        state_n   = (hdr_cnt_i == MOLD_CNT_HB) ? IDLE : PKT;
      end else begin
        if (gap_gt_s) begin
          gap_v_n   = 1'b1;
          gap_seq_n = exp_base_s;
          gap_cnt_n = gap_min_s;
          exp_n     = hdr_seq_i;
        end else begin
          exp_n     = exp_base_s;
        end
        if (hdr_cnt_i == MOLD_CNT_EOS) begin
          eos_n   = 1'b1;
          state_n = EOS;
        end else if (hdr_cnt_i == MOLD_CNT_HB) begin
          state_n = IDLE;
        end else begin
          drop_n  = 1'b0;
          skip_n  = skip_gt_s ? skip_min_s : 16'd0;
          rem_n   = hdr_cnt_i;
          cur_n   = hdr_seq_i;
          state_n = PKT;
        end
      end
    end else begin
      hdr_go_s = 1'b0;
    end

    accept_n = (state_n == PKT) && !drop_n && (skip_n == 16'd0);
  end

  // Controller state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= UNLOCKED;
      sid_r       <= '0;
      expected_r  <= '0;
      cur_seq_r   <= '0;
      remaining_r <= '0;
      skip_r      <= '0;
      drop_all_r  <= 1'b0;
      locked_r    <= 1'b0;
      eos_r       <= 1'b0;
      gap_v_r     <= 1'b0;
      gap_seq_r   <= '0;
      gap_cnt_r   <= '0;
      sid_err_r   <= 1'b0;
      trunc_r     <= 1'b0;
      accept_r    <= 1'b0;
    end else begin
      state_r     <= state_n;
      sid_r       <= sid_n;
      expected_r  <= exp_n;
      cur_seq_r   <= cur_n;
      remaining_r <= rem_n;
      skip_r      <= skip_n;
      drop_all_r  <= drop_n;
      locked_r    <= locked_n;
      eos_r       <= eos_n;
      gap_v_r     <= gap_v_n;
      gap_seq_r   <= gap_seq_n;
      gap_cnt_r   <= gap_cnt_n;
      sid_err_r   <= sid_err_n;
      trunc_r     <= trunc_n;
      accept_r    <= accept_n;
    end
  end

  assign msg_accept_o = accept_r;
  assign msg_seq_o    = cur_seq_r;
  assign locked_o     = locked_r;
  assign eos_o        = eos_r;
  assign gap_v_o      = gap_v_r;
  assign gap_seq_o    = gap_seq_r;
  assign gap_cnt_o    = gap_cnt_r;
  assign sid_err_o    = sid_err_r;
  assign trunc_err_o  = trunc_r;

`ifdef MOLD_SEQ_STATS_EN
  logic [31:0] stat_acc_r, stat_dup_r, stat_gap_r;
  logic        msg_done_s;

  assign msg_done_s = (state_r == PKT) && !hdr_v_i && msg_end_i;

  // Saturating accepted / skipped / gap event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_acc_r <= 32'd0;
      stat_dup_r <= 32'd0;
      stat_gap_r <= 32'd0;
    end else begin
      if (msg_done_s && accept_r) stat_acc_r <= sat_inc32(stat_acc_r);
      if (msg_done_s && (skip_r != 16'd0)) stat_dup_r <= sat_inc32(stat_dup_r);
      if (gap_v_n) stat_gap_r <= sat_inc32(stat_gap_r);
    end
  end

  assign stat_acc_o = stat_acc_r;
  assign stat_dup_o = stat_dup_r;
  assign stat_gap_o = stat_gap_r;
`else
  assign stat_acc_o = 32'd0;
  assign stat_dup_o = 32'd0;
  assign stat_gap_o = 32'd0;
`endif

endmodule
